peripheral_comunicaciones_rx: RTL and testbench

//  UART receive peripheral on the j1 I/O bus; the inbound side of the WIFI serial link.

---
 rtl/peripheral_comunicaciones_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_peripheral_comunicaciones_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_comunicaciones_rx.sv
// UART 8N1 receiver with a read FIFO on the j1 I/O bus (WIFI link inbound).
// Ports: clk, rst (async low), bus cs/addr/rd/wr/d_in/d_out, serial rx. Option: RX_TIMEOUT_EN.
module peripheral_comunicaciones_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  input  logic        rx
);

  localparam int BIT_DIV = CLK_HZ / BAUD;
  localparam int HALF    = BIT_DIV / 2;
  localparam int CTW     = $clog2(BIT_DIV + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam logic [CTW-1:0] HALF_T = CTW'(HALF);
  localparam logic [CTW-1:0] BIT_T  = CTW'(BIT_DIV - 1);
  localparam logic [CW-1:0]  FULL_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;

  logic           rx_s1_q, rx_s2_q, rx_prev_q;
  state_t         state_q, state_d;
  logic [CTW-1:0] cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           rx_fall, push_req, ferr_set, start_evt;

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           rd_prev_q, rd_acc, clr_wr;
  logic           empty, full, do_pop, do_push, ovr_set;
  logic           ovr_q, ovr_d, ferr_q, ferr_d, tmo;
  logic [7:0]     cnt8;
  logic           unused_ok;

  // rx is asynchronous: two-flop synchroniser, plus a delayed copy for edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_fall) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_T) begin
          cnt_d   = '0;
          state_d = rx_s2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_T) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_T) begin
          cnt_d   = '0;
          state_d = rx_s2_q ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    start_evt = 1'b0;
    if (state_q == S_STOP && cnt_q == BIT_T) begin
      push_req = rx_s2_q;
      ferr_set = ~rx_s2_q;
    end
    if (state_q == S_IDLE && rx_fall) start_evt = 1'b1;
  end

  // pop once per access: edge-detect the DATA read strobe
  assign rd_acc  = cs && rd && (addr == 4'h0);
  assign clr_wr  = cs && wr && (addr == 4'h4);
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_C);
  assign do_pop  = rd_acc && !rd_prev_q && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = push_req && (!full || do_pop);
  assign ovr_set = push_req && full && !do_pop;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
    ovr_d  = ovr_set  | (ovr_q  & ~(clr_wr & d_in[2]));
    ferr_d = ferr_set | (ferr_q & ~(clr_wr & d_in[3]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_prev_q <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_prev_q <= rd_acc;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

`ifdef RX_TIMEOUT_EN
  localparam int TO_CLKS = 40 * BIT_DIV;
  localparam int TW      = $clog2(TO_CLKS + 1);
  localparam logic [TW-1:0] TO_SAT = TW'(TO_CLKS);
  localparam logic [TW-1:0] TO_HIT = TW'(TO_CLKS - 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          tmo_q, tmo_d, to_run, to_clr, to_set;

  assign to_run = (state_q == S_IDLE) && !empty;
  assign to_clr = start_evt | do_push | do_pop;
  assign to_set = to_run && !to_clr && (to_cnt_q == TO_HIT);

  // counter saturates so the flag fires once per idle stretch
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (to_clr) to_cnt_d = '0;
    else if (to_run && to_cnt_q != TO_SAT) to_cnt_d = to_cnt_q + 1'b1;
    tmo_d = to_set | (tmo_q & ~(clr_wr & d_in[4]) & ~do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign tmo       = tmo_q;
  assign unused_ok = ^{d_in[15:5], d_in[1:0]};
`else
  assign tmo       = 1'b0;
  assign unused_ok = ^{d_in[15:4], d_in[1:0]};
`endif

  assign cnt8 = 8'(count_q);

  always_comb begin
    d_out = '0;
    if (cs) begin
      case (addr)
        4'h0: if (!empty) d_out = {8'h00, mem_q[rd_ptr_q]};
        4'h2: d_out = {3'b000, cnt8, tmo, ferr_q, ovr_q, full, !empty};
        default: d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_comunicaciones_rx.sv
// Bench for peripheral_comunicaciones_rx: serial stimulus, FIFO scoreboard.
// Uses a fast baud (BIT_DIV=16) to keep the run short; honours RX_TIMEOUT_EN.
module tb_peripheral_comunicaciones_rx;

  localparam int BD    = 16;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] d_in = '0;
  logic        cs = 1'b0;
  logic [3:0]  addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] d_out;
  logic        rx = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sb [$];
  logic       exp_ovr = 1'b0;
  logic       exp_ferr = 1'b0;

  peripheral_comunicaciones_rx #(
    .CLK_HZ(50000000),
    .BAUD(3125000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr),
    .rd(rd), .wr(wr), .d_out(d_out), .rx(rx)
  );

  always #10 clk = ~clk;

  function automatic logic [15:0] exp_status(input logic tmo);
    logic [7:0] c;
    c = 8'(sb.size());
    return {3'b000, c, tmo, exp_ferr, exp_ovr,
            sb.size() == DEPTH, sb.size() != 0};
  endfunction

  task automatic bus_read(input logic [3:0] a, output logic [15:0] v);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    #2 v = d_out;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; addr = '0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk);
    rx = 1'b0;
    repeat (BD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(posedge clk);
    end
    rx = stop;
    repeat (BD) @(posedge clk);
    rx = 1'b1;
    repeat (2 * BD) @(posedge clk);
    if (!stop) exp_ferr = 1'b1;
    else if (sb.size() < DEPTH) sb.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic check_status(input string name, input logic tmo);
    logic [15:0] v, e;
    e = exp_status(tmo);
    bus_read(4'h2, v);
    vectors++;
    if (v !== e) begin
      miscompares++;
      $display("FAIL %s status got %h want %h", name, v, e);
    end
  endtask

  task automatic check_pop(input string name);
    logic [15:0] v, e;
    e = '0;
    if (sb.size() != 0) e = {8'h00, sb.pop_front()};
    bus_read(4'h0, v);
    vectors++;
    if (v !== e) begin
      miscompares++;
      $display("FAIL %s data got %h want %h", name, v, e);
    end
  endtask

  task automatic test_reset;
    logic [15:0] v;
    repeat (4) @(posedge clk);
    @(negedge clk);
    cs = 1'b1; addr = 4'h2;
    #2 v = d_out;
    vectors++;
    if (v !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_status got %h want %h", v, 16'h0000);
    end
    cs = 1'b0; addr = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    check_status("post_reset", 1'b0);
    check_pop("post_reset");
  endtask

  task automatic test_ok;
    logic [15:0] v;
    send_byte(8'h4F, 1'b1);
    send_byte(8'h4B, 1'b1);
    check_status("ok_two", 1'b0);
    @(negedge clk);
    cs = 1'b0; rd = 1'b1; addr = 4'h2;
    #2 v = d_out;
    vectors++;
    if (v !== 16'h0000) begin
      miscompares++;
      $display("FAIL cs_low got %h want %h", v, 16'h0000);
    end
    rd = 1'b0; addr = '0;
    check_pop("ok_first");
    check_pop("ok_second");
    check_pop("ok_empty");
    check_status("ok_drained", 1'b0);
  endtask

  task automatic test_hold_pop;
    logic [15:0] v, e;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    e = {8'h00, sb.pop_front()};
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = 4'h0;
    #2 v = d_out;
    vectors++;
    if (v !== e) begin
      miscompares++;
      $display("FAIL hold_data got %h want %h", v, e);
    end
    repeat (5) @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    check_status("hold_count", 1'b0);
    check_pop("hold_second");
    check_status("hold_drained", 1'b0);
  endtask

  task automatic test_overrun;
    for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b1);
    check_status("ovr_full", 1'b0);
    for (int i = 0; i < DEPTH; i++) check_pop("ovr_read");
    bus_write(4'h4, 16'h0004);
    exp_ovr = 1'b0;
    check_status("ovr_clear", 1'b0);
  endtask

  task automatic test_frame;
    send_byte(8'hA5, 1'b0);
    check_status("frame_err", 1'b0);
    send_byte(8'h5A, 1'b1);
    check_status("frame_next", 1'b0);
    check_pop("frame_next");
    bus_write(4'h4, 16'h0008);
    exp_ferr = 1'b0;
    check_status("frame_clear", 1'b0);
  endtask

  task automatic test_glitch;
    @(posedge clk);
    rx = 1'b0;
    repeat (10) @(posedge clk);
    rx = 1'b1;
    repeat (3 * BD) @(posedge clk);
    check_status("glitch", 1'b0);
    check_pop("glitch");
  endtask

  task automatic test_reset_mid;
    @(posedge clk);
    rx = 1'b0;
    repeat (4 * BD) @(posedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    rst = 1'b1;
    repeat (2 * BD) @(posedge clk);
    check_status("rst_mid_empty", 1'b0);
    send_byte(8'h31, 1'b1);
    check_status("rst_mid_one", 1'b0);
    check_pop("rst_mid");
    check_pop("rst_mid_empty");
  endtask

  task automatic test_timeout;
    logic t;
`ifdef RX_TIMEOUT_EN
    t = 1'b1;
`else
    t = 1'b0;
`endif
    send_byte(8'h77, 1'b1);
    repeat (30 * BD) @(posedge clk);
    check_status("tmo_early", 1'b0);
    repeat (15 * BD) @(posedge clk);
    check_status("tmo_late", t);
    check_pop("tmo_pop");
    check_status("tmo_after_pop", 1'b0);
  endtask

  initial begin
    test_reset();
    test_ok();
    test_hold_pop();
    test_overrun();
    test_frame();
    test_glitch();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
